// File: rtl/shift_sequencer_pkg.sv
// Shared op and FSM encodings for the shift sequencer and its bench.
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    SHOP_SLL  = 2'b00,
    SHOP_SRL  = 2'b01,
    SHOP_SRA  = 2'b10,
    SHOP_ROTR = 2'b11
  } shop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_P1   = 2'b01,
    ST_P2   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bus between ALU issue logic, the shift sequencer and writeback.
// Handshake: a beat transfers on a rising edge where valid && ready; a producer
// holds valid and its payload stable until that edge, and ready may depend on valid.
interface shift_sequencer_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_data;
  logic [4:0]       req_amt;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_err;

  modport master (
    output req_valid, req_op, req_data, req_amt, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_data, req_amt, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag, resp_err
  );
endinterface

// File: rtl/shift_sequencer_shifter.sv
// Plain 32-bit logical barrel shifter; direction=1 shifts right, 0 shifts left.
module shifter (
  input  logic [31:0] toshift,
  input  logic [4:0]  number,
  input  logic        direction,
  output logic [31:0] shifted
);
  assign shifted = direction ? (toshift >> number) : (toshift << number);
endmodule

// File: rtl/shift_sequencer.sv
// Time-shares one logical shifter to run SLL/SRL/SRA/ROTR; SRA and ROTR take
// a second pass (fill mask, wrapped-around bits) that is OR-combined with the first.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter bit ROTR_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  shift_sequencer_if.slave   bus,
  output logic               busy,
  output state_e             dbg_state
);

  state_e           state;
  shop_e            op_q;
  logic [31:0]      data_q;
  logic [4:0]       amt_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      tmp_q;

  logic [31:0] sh_in;
  logic [4:0]  sh_num;
  logic        sh_dir;
  logic [31:0] sh_out;
  logic [31:0] p2_result;
  logic        rotr_unsupported;
  logic        two_pass;
  logic        accept;

  assign bus.req_ready = !flush &&
                         (state == ST_IDLE || (state == ST_RESP && bus.resp_ready));
  assign accept        = bus.req_valid && bus.req_ready;
  assign busy          = (state != ST_IDLE);
  assign dbg_state     = state;

  assign rotr_unsupported = (op_q == SHOP_ROTR) && !ROTR_EN;
  assign two_pass = (amt_q != 5'd0) &&
                    (op_q == SHOP_SRA || (op_q == SHOP_ROTR && ROTR_EN));

  always_comb begin
    sh_in  = data_q;
    sh_num = amt_q;
    sh_dir = (op_q != SHOP_SLL);
    if (state == ST_P2) begin
      if (op_q == SHOP_SRA) begin
        sh_in  = 32'hFFFF_FFFF;
        sh_dir = 1'b1;
      end else begin
        // (32 - amt) mod 32; amt is never 0 here, so this is a true 1..31 left shift.
        sh_num = 5'd0 - amt_q;
        sh_dir = 1'b0;
      end
    end
  end

  shifter u_shifter (
    .toshift   (sh_in),
    .number    (sh_num),
    .direction (sh_dir),
    .shifted   (sh_out)
  );

  // Second pass output is the right-shift mask for SRA, the wrapped bits for ROTR.
  assign p2_result = (op_q == SHOP_SRA) ? (data_q[31] ? (tmp_q | ~sh_out) : tmp_q)
                                        : (tmp_q | sh_out);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      op_q           <= SHOP_SLL;
      data_q         <= '0;
      amt_q          <= '0;
      tag_q          <= '0;
      tmp_q          <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_tag   <= '0;
      bus.resp_err   <= 1'b0;
    end else if (flush) begin
      state          <= ST_IDLE;
      bus.resp_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= shop_e'(bus.req_op);
            data_q <= bus.req_data;
            amt_q  <= bus.req_amt;
            tag_q  <= bus.req_tag;
            state  <= ST_P1;
          end
        end
        ST_P1: begin
          if (two_pass) begin
            tmp_q <= sh_out;
            state <= ST_P2;
          end else begin
            bus.resp_data  <= sh_out;
            bus.resp_tag   <= tag_q;
            bus.resp_err   <= rotr_unsupported;
            bus.resp_valid <= 1'b1;
            state          <= ST_RESP;
          end
        end
        ST_P2: begin
          bus.resp_data  <= p2_result;
          bus.resp_tag   <= tag_q;
          bus.resp_err   <= 1'b0;
          bus.resp_valid <= 1'b1;
          state          <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            if (accept) begin
              op_q   <= shop_e'(bus.req_op);
              data_q <= bus.req_data;
              amt_q  <= bus.req_amt;
              tag_q  <= bus.req_tag;
              state  <= ST_P1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: latency, results, backpressure, flush,
// async reset, and the ROTR_EN=0 fallback on a second instance.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  logic   clk;
  logic   reset_n;
  logic   flush;
  logic   nb_flush;
  logic   busy;
  logic   nb_busy;
  state_e dbg_state;
  state_e nb_dbg_state;
  int     checks;
  int     failures;

  shift_sequencer_if #(.TAG_W(4)) bus ();
  shift_sequencer_if #(.TAG_W(4)) nb  ();

  shift_sequencer #(.TAG_W(4), .ROTR_EN(1'b1)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  shift_sequencer #(.TAG_W(4), .ROTR_EN(1'b0)) u_dut_norot (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (nb_flush),
    .bus       (nb),
    .busy      (nb_busy),
    .dbg_state (nb_dbg_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns one cycle later (accept cycle t -> t+1).
  task automatic send(input logic [1:0] op, input logic [31:0] data,
                      input logic [4:0] amt, input logic [3:0] tag);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = data;
    bus.req_amt   = amt;
    bus.req_tag   = tag;
    #1 chk("req_ready_on_send", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Called at t+1; checks resp_valid rises exactly at t+lat, then consumes it.
  task automatic expect_resp(input string name, input int lat, input logic [31:0] data,
                             input logic [3:0] tag, input logic err);
    for (int c = 1; c < lat; c++) begin
      #1 chk({name, "_early_valid"}, 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
    end
    #1 chk({name, "_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({name, "_data"}, bus.resp_data, data);
    chk({name, "_tag"}, 32'(bus.resp_tag), 32'(tag));
    chk({name, "_err"}, 32'(bus.resp_err), 32'(err));
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    #1 chk({name, "_valid_drop"}, 32'(bus.resp_valid), 32'd0);
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    flush = 1'b0;
    nb_flush = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_data = '0;
    bus.req_amt = '0; bus.req_tag = '0; bus.resp_ready = 1'b0;
    nb.req_valid = 1'b0; nb.req_op = 2'b00; nb.req_data = '0;
    nb.req_amt = '0; nb.req_tag = '0; nb.resp_ready = 1'b0;

    // reset state
    #1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_resp_tag", 32'(bus.resp_tag), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("idle_req_ready", 32'(bus.req_ready), 32'd1);

    // single-pass and two-pass ops
    send(2'b00, 32'h0000_0001, 5'd4, 4'd3);
    expect_resp("sll", 2, 32'h0000_0010, 4'd3, 1'b0);
    send(2'b10, 32'h8000_0000, 5'd4, 4'd1);
    expect_resp("sra_neg", 3, 32'hF800_0000, 4'd1, 1'b0);
    send(2'b10, 32'h7000_0000, 5'd4, 4'd2);
    expect_resp("sra_pos", 3, 32'h0700_0000, 4'd2, 1'b0);
    send(2'b10, 32'h8000_0000, 5'd0, 4'd4);
    expect_resp("sra_amt0", 2, 32'h8000_0000, 4'd4, 1'b0);
    send(2'b11, 32'h0000_00F1, 5'd4, 4'd5);
    expect_resp("rotr_4", 3, 32'h1000_000F, 4'd5, 1'b0);
    send(2'b11, 32'hDEAD_BEEF, 5'd31, 4'd6);
    expect_resp("rotr_31", 3, 32'hBD5B_7DDF, 4'd6, 1'b0);
    send(2'b11, 32'h1234_5678, 5'd0, 4'd7);
    expect_resp("rotr_amt0", 2, 32'h1234_5678, 4'd7, 1'b0);
    send(2'b01, 32'hF000_0000, 5'd31, 4'd8);
    expect_resp("srl_31", 2, 32'h0000_0001, 4'd8, 1'b0);

    // backpressure, then back-to-back accept on the releasing handshake
    send(2'b00, 32'h0000_0003, 5'd1, 4'd5);
    #1 chk("bp_p1_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_data  = 32'h8000_0000;
    bus.req_amt   = 5'd31;
    bus.req_tag   = 4'd9;
    for (int c = 0; c < 5; c++) begin
      #1 chk("bp_valid_hold", 32'(bus.resp_valid), 32'd1);
      chk("bp_data_hold", bus.resp_data, 32'h0000_0006);
      chk("bp_tag_hold", 32'(bus.resp_tag), 32'd5);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    #1 chk("b2b_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    #1 chk("b2b_busy", 32'(busy), 32'd1);
    expect_resp("b2b_srl", 2, 32'h0000_0001, 4'd9, 1'b0);

    // flush during P2 of an SRA
    send(2'b10, 32'h8000_0000, 5'd8, 4'd2);
    @(negedge clk);
    #1 chk("flush_in_p2", 32'(dbg_state), 32'(ST_P2));
    flush = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    #1 chk("flush_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    bus.req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1 chk("flush_no_resp", 32'(bus.resp_valid), 32'd0);
      chk("flush_idle", 32'(busy), 32'd0);
      @(negedge clk);
    end
    send(2'b00, 32'h0000_000A, 5'd4, 4'd4);
    expect_resp("post_flush_sll", 2, 32'h0000_00A0, 4'd4, 1'b0);

    // flush in RESP wins over resp_ready and blocks a new accept
    send(2'b00, 32'h0000_0001, 5'd1, 4'd6);
    @(negedge clk);
    #1 chk("flushresp_valid", 32'(bus.resp_valid), 32'd1);
    flush = 1'b1;
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    #1 chk("flushresp_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b0;
    #1 chk("flushresp_dropped", 32'(bus.resp_valid), 32'd0);
    chk("flushresp_no_accept", 32'(busy), 32'd0);
    @(negedge clk);
    #1 chk("flushresp_still_idle", 32'(dbg_state), 32'(ST_IDLE));

    // async reset mid-P1: outputs clear before the next clock edge
    send(2'b01, 32'h0000_00FF, 5'd4, 4'd7);
    #1 chk("arst_p1_busy", 32'(busy), 32'd1);
    #1 reset_n = 1'b0;
    #1 chk("arst_p1_busy_clr", 32'(busy), 32'd0);
    chk("arst_p1_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 chk("arst_no_resp", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
    end

    // async reset while a response is pending
    send(2'b00, 32'h0000_00FF, 5'd4, 4'd12);
    @(negedge clk);
    #1 chk("arst_resp_data_pre", bus.resp_data, 32'h0000_0FF0);
    #1 reset_n = 1'b0;
    #1 chk("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("arst_resp_data", bus.resp_data, 32'd0);
    chk("arst_resp_tag", 32'(bus.resp_tag), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // ROTR_EN=0 instance: ROTR runs as SRL and flags resp_err
    nb.req_valid = 1'b1;
    nb.req_op    = 2'b11;
    nb.req_data  = 32'h0000_00F0;
    nb.req_amt   = 5'd4;
    nb.req_tag   = 4'd1;
    #1 chk("norot_req_ready", 32'(nb.req_ready), 32'd1);
    @(negedge clk);
    nb.req_valid = 1'b0;
    #1 chk("norot_early_valid", 32'(nb.resp_valid), 32'd0);
    @(negedge clk);
    #1 chk("norot_valid", 32'(nb.resp_valid), 32'd1);
    chk("norot_data", nb.resp_data, 32'h0000_000F);
    chk("norot_err", 32'(nb.resp_err), 32'd1);
    chk("norot_tag", 32'(nb.resp_tag), 32'd1);
    nb.resp_ready = 1'b1;
    @(negedge clk);
    nb.resp_ready = 1'b0;
    nb.req_valid = 1'b1;
    nb.req_op    = 2'b10;
    nb.req_data  = 32'h8000_0000;
    nb.req_amt   = 5'd4;
    nb.req_tag   = 4'd2;
    @(negedge clk);
    nb.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("norot_sra_data", nb.resp_data, 32'hF800_0000);
    chk("norot_sra_err", 32'(nb.resp_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller that time-shares one 32-bit logical `shifter` instance to execute the four shift ops the execute stage needs: SLL, SRL, SRA, ROTR.
- SRA and ROTR are built from two logical-shift passes through the same shifter, sequenced by an FSM.
- Sits between the ALU issue logic (valid/ready request side) and the writeback mux (valid/ready response side).

Parameters:
- TAG_W, 4, width of the opaque request tag returned with the result.
- ROTR_EN, 1, when 0 op ROTR is unsupported: it executes as SRL and raises resp_err.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of the in-flight op.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when valid&&ready.
- req_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTR.
- req_data  input  32  operand.
- req_amt  input  5  shift amount, 0..31.
- req_tag  input  TAG_W  returned unchanged.
- resp_valid  output  1  result present.
- resp_ready  input  1  consumer accepts when valid&&ready.
- resp_data  output  32  result.
- resp_tag  output  TAG_W  tag of the result.
- resp_err  output  1  unsupported op executed (ROTR with ROTR_EN=0).
- busy  output  1  state != IDLE.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; resp_valid, resp_data, resp_tag, resp_err and busy = 0; operand and tmp registers = 0.
- FSM states: IDLE, P1, P2, RESP.
- req_ready = !flush && (state==IDLE || (state==RESP && resp_ready)).
- Accept: latch op, data, amt, tag, then go to P1.
- P1: shifter inputs toshift=data, number=amt, direction=(op!=SLL). Latch tmp = shifter output.
  - SLL, SRL, or any op with amt==0: resp_data=tmp, go to RESP.
  - Otherwise go to P2.
- P2 for SRA: toshift=32'hFFFF_FFFF, number=amt, direction=right, giving mask. resp_data = data[31] ? (tmp | ~mask) : tmp.
- P2 for ROTR: toshift=data, number=(6'd32-amt)[4:0], direction=left. resp_data = tmp | shifter output. amt==0 never reaches P2, so the shift-by-32 case cannot occur.
- After P2, go to RESP.
- RESP: resp_valid=1. resp_data, resp_tag and resp_err are held stable until resp_ready.
  - On handshake with no new accept: go to IDLE and drop resp_valid.
  - On handshake with a same-cycle accept: go straight to P1.
- Latency from accept cycle t:
  - SLL, SRL, and amt==0: resp_valid at t+2.
  - SRA and ROTR: resp_valid at t+3.
- Throughput: one op per 2 cycles (single-pass) or 3 cycles (two-pass) when resp_ready is held high.
- Shifter use: one instance only, driven combinationally from state; its inputs are don't-care in IDLE and RESP.
- Flush: any state goes to IDLE next cycle and resp_valid drops. A pending response is discarded even if resp_ready is high in the same cycle (flush wins). No accept occurs in a flush cycle.
- ROTR_EN=0: op 11 follows the SRL path (single pass), resp_err=1. resp_err=0 for all other ops.
- reset_n asserted mid-op: all outputs clear immediately; no response is ever produced for the aborted op.
- No other error or overflow conditions: req_amt is 5 bits, so every amount is legal.

Decomposition:
- Shared defines header (guarded include) holds op encodings SHOP_SLL/SRL/SRA/ROTR and FSM state encodings (2-bit).
- One sub-module: the existing `shifter` (toshift, number, direction → shifted), instantiated once.
- Sequencing, masking and OR-combine logic stay in shift_sequencer.

Test Plan:
1. SLL data=0x0000_0001 amt=4, tag=3, accepted at t → resp_valid at t+2, resp_data=0x0000_0010, resp_tag=3, resp_err=0.
2. SRA 0x8000_0000 amt=4 → 0xF800_0000 at t+3. SRA 0x7000_0000 amt=4 → 0x0700_0000. SRA 0x8000_0000 amt=0 → 0x8000_0000 at t+2.
3. ROTR 0x0000_00F1 amt=4 → 0x1000_000F at t+3. ROTR 0xDEAD_BEEF amt=31 → 0xBD5B_7DDF. ROTR amt=0 → operand unchanged at t+2.
4. Backpressure: hold resp_ready=0 for 5 cycles after resp_valid → resp_data and resp_tag stable, req_ready=0. Then raise resp_ready with req_valid=1 → new op accepted in the same cycle and its result is correct.
5. Flush while in P2 of an SRA → no response ever appears; the next SLL completes correctly. Flush in RESP with resp_ready=1 → no handshake is counted.
6. Async reset_n pulse mid-P1 → outputs go to 0 without waiting for a clock edge. With ROTR_EN=0: op 11 on 0x0000_00F0 amt=4 → 0x0000_000F, resp_err=1.
